// File: rtl/ram_pkg.sv
// Shared RAM geometry plus the arbiter's state encoding.
package ram_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned DEPTH      = 16;
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_RESP
  } arb_state_e;

  // Index width for a requester vector; never zero even for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational one-hot requester picker: round-robin from ptr, or fixed priority
// (requester 0 highest) when RAM_ARB_FIXED_PRIORITY_EN is defined.
module rr_grant #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

`ifdef RAM_ARB_FIXED_PRIORITY_EN

  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!any && req[IDX_W'(k)]) begin
        any                = 1'b1;
        gnt[IDX_W'(k)]     = 1'b1;
        idx                = IDX_W'(k);
      end
    end
  end

`else

  always_comb begin
    int unsigned j;
    logic [IDX_W-1:0] jj;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    // Search starts at ptr and wraps modulo NUM_REQ.
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j  = (32'(ptr) + k) % NUM_REQ;
      jj = IDX_W'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

`endif

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one single-port RAM between NUM_REQ requesters, one access in flight.
// Define RAM_ARB_FIXED_PRIORITY_EN for fixed priority instead of round-robin.
module ram_access_arbiter
  import ram_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = ram_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = ram_pkg::ADDR_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            ram_cs,
  output logic                            ram_we,
  output logic                            ram_oe,
  output logic [ADDR_WIDTH-1:0]           ram_addr,
  output logic [DATA_WIDTH-1:0]           ram_wdata,
  input  logic [DATA_WIDTH-1:0]           ram_rdata
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic                    ram_cs_q, ram_cs_d;
  logic                    ram_we_q, ram_we_d;
  logic                    ram_oe_q, ram_oe_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;

  logic [IDX_W-1:0]        grant_ptr;
  logic [NUM_REQ-1:0]      grant;
  logic [IDX_W-1:0]        grant_idx;
  logic                    grant_any;

`ifdef RAM_ARB_FIXED_PRIORITY_EN
  assign grant_ptr = '0;
`else
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;

  assign grant_ptr = rr_ptr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == ARB_IDLE && grant_any) begin
      rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_grant (
    .req (req_valid),
    .ptr (grant_ptr),
    .gnt (grant),
    .idx (grant_idx),
    .any (grant_any)
  );

  assign req_ready = (state_q == ARB_IDLE) ? grant : '0;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ram_cs_d    = ram_cs_q;
    ram_we_d    = ram_we_q;
    ram_oe_d    = ram_oe_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (grant_any) begin
          state_d     = ARB_ACCESS;
          owner_d     = grant_idx;
          ram_cs_d    = 1'b1;
          ram_we_d    = req_we[grant_idx];
          ram_oe_d    = ~req_we[grant_idx];
          ram_addr_d  = req_addr[32'(grant_idx) * ADDR_WIDTH +: ADDR_WIDTH];
          ram_wdata_d = req_wdata[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
        end
      end
      ARB_ACCESS: begin
        state_d  = ram_we_q ? ARB_IDLE : ARB_RESP;
        ram_cs_d = 1'b0;
        ram_we_d = 1'b0;
        ram_oe_d = 1'b0;
      end
      ARB_RESP: begin
        // Only place ram_rdata is sampled; it is Z everywhere else.
        state_d              = ARB_IDLE;
        rsp_data_d           = ram_rdata;
        rsp_valid_d[owner_q] = 1'b1;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      owner_q     <= '0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_oe_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ram_cs_q    <= ram_cs_d;
      ram_we_q    <= ram_we_d;
      ram_oe_q    <= ram_oe_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign ram_cs    = ram_cs_q;
  assign ram_we    = ram_we_q;
  assign ram_oe    = ram_oe_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter (4 requesters) with a behavioural registered RAM.
module tb_ram_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  rsp_data;
  logic        ram_cs, ram_we, ram_oe;
  logic [3:0]  ram_addr;
  logic [7:0]  ram_wdata;
  wire  [7:0]  ram_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_access_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_oe    (ram_oe),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Single-port RAM: registered read data driven only in the cycle after a read.
  logic [7:0] mem [16];
  logic [7:0] rd_q;
  logic       rd_en_q = 1'b0;

  initial for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);

  always @(posedge clk) begin
    rd_en_q <= 1'b0;
    if (ram_cs) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
      end else if (ram_oe) begin
        rd_q    <= mem[ram_addr];
        rd_en_q <= 1'b1;
      end
    end
  end

  assign ram_rdata = rd_en_q ? rd_q : 8'hzz;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic [3:0] a,
                         input logic [7:0] d);
    req_valid[i]       = v;
    req_we[i]          = we;
    req_addr[i*4 +: 4] = a;
    req_wdata[i*8 +: 8] = d;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, 32'(req_ready), 32'h0);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check_eq({tag, "_rsp_data"}, 32'(rsp_data), 32'h0);
    check_eq({tag, "_cs_we_oe"}, {29'h0, ram_cs, ram_we, ram_oe}, 32'h0);
    check_eq({tag, "_addr"}, 32'(ram_addr), 32'h0);
    check_eq({tag, "_wdata"}, 32'(ram_wdata), 32'h0);
  endtask

  logic [3:0] exp_g [4];

  initial begin
`ifdef RAM_ARB_FIXED_PRIORITY_EN
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0001; exp_g[2] = 4'b0001; exp_g[3] = 4'b0001;
`else
    exp_g[0] = 4'b0010; exp_g[1] = 4'b0001; exp_g[2] = 4'b0010; exp_g[3] = 4'b0001;
`endif
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    rst_n = 1'b0;
    tick();
    check_all_zero("rst");
    rst_n = 1'b1;
    tick();

    // Write A5 to addr 5 from req0
    set_req(0, 1'b1, 1'b1, 4'd5, 8'hA5);
    #1 check_eq("wr_ready", 32'(req_ready), 32'h1);
    tick();
    check_eq("wr_cs_we_oe", {29'h0, ram_cs, ram_we, ram_oe}, 32'h6);
    check_eq("wr_addr", 32'(ram_addr), 32'h5);
    check_eq("wr_wdata", 32'(ram_wdata), 32'hA5);
    check_eq("wr_access_ready", 32'(req_ready), 32'h0);
    req_valid[0] = 1'b0;
    tick();
    check_eq("wr_done_cs", 32'(ram_cs), 32'h0);

    // Read back addr 5: response 3 cycles after accept
    set_req(0, 1'b1, 1'b0, 4'd5, 8'h00);
    #1 check_eq("rd_ready", 32'(req_ready), 32'h1);
    tick();
    check_eq("rd_cs_we_oe", {29'h0, ram_cs, ram_we, ram_oe}, 32'h5);
    req_valid[0] = 1'b0;
    tick();
    check_eq("rd_resp_cyc_valid", 32'(rsp_valid), 32'h0);
    check_eq("rd_resp_cyc_cs", 32'(ram_cs), 32'h0);
    tick();
    check_eq("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("rd_rsp_data", 32'(rsp_data), 32'hA5);
    tick();
    check_eq("rd_pulse_end", 32'(rsp_valid), 32'h0);
    check_eq("rd_data_hold", 32'(rsp_data), 32'hA5);

    // Idle with RAM output floating
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("idle_rsp_valid", 32'(rsp_valid), 32'h0);
      check_eq("idle_rsp_data", 32'(rsp_data), 32'hA5);
    end

    // Contention: req0 reads addr 1, req1 reads addr 2, both held valid
    set_req(0, 1'b1, 1'b0, 4'd1, 8'h00);
    set_req(1, 1'b1, 1'b0, 4'd2, 8'h00);
    for (int k = 0; k < 4; k++) begin
      #1 check_eq("cont_gnt", 32'(req_ready), 32'(exp_g[k]));
      if (k > 0) begin
        check_eq("cont_rsp_valid", 32'(rsp_valid), 32'(exp_g[k-1]));
        check_eq("cont_rsp_data", 32'(rsp_data),
                 (exp_g[k-1] == 4'b0001) ? 32'h11 : 32'h12);
      end
      tick();
      check_eq("cont_busy_ready", 32'(req_ready), 32'h0);
      check_eq("cont_busy_rsp", 32'(rsp_valid), 32'h0);
      tick();
      check_eq("cont_busy_ready", 32'(req_ready), 32'h0);
      check_eq("cont_busy_rsp", 32'(rsp_valid), 32'h0);
      tick();
    end
    check_eq("cont_last_rsp_valid", 32'(rsp_valid), 32'(exp_g[3]));
    check_eq("cont_last_rsp_data", 32'(rsp_data),
             (exp_g[3] == 4'b0001) ? 32'h11 : 32'h12);
    req_valid[0] = 1'b0;
    #1 check_eq("req1_after_drop", 32'(req_ready), 32'h2);
    tick();
    req_valid[1] = 1'b0;
    tick();
    tick();
    check_eq("req1_rsp_valid", 32'(rsp_valid), 32'h2);
    check_eq("req1_rsp_data", 32'(rsp_data), 32'h12);

    // Wrap-around: grant req3, then req0 must beat req3
    set_req(3, 1'b1, 1'b0, 4'd3, 8'h00);
    #1 check_eq("wrap_gnt3", 32'(req_ready), 32'h8);
    tick();
    req_valid[3] = 1'b0;
    tick();
    tick();
    check_eq("wrap_rsp3", 32'(rsp_valid), 32'h8);
    check_eq("wrap_data3", 32'(rsp_data), 32'h13);
    set_req(0, 1'b1, 1'b0, 4'd4, 8'h00);
    set_req(3, 1'b1, 1'b0, 4'd6, 8'h00);
    #1 check_eq("wrap_gnt0", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick();
    tick();
    check_eq("wrap_rsp0", 32'(rsp_valid), 32'h1);
    check_eq("wrap_data0", 32'(rsp_data), 32'h14);

    // Reset during RESP of a req2 read
    set_req(2, 1'b1, 1'b0, 4'd7, 8'h00);
    #1 check_eq("mid_gnt2", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    #1 check_all_zero("mid_rst");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("post_rst_rsp", 32'(rsp_valid), 32'h0);
      check_eq("post_rst_cs", 32'(ram_cs), 32'h0);
    end
    set_req(0, 1'b1, 1'b0, 4'd8, 8'h00);
    set_req(3, 1'b1, 1'b0, 4'd9, 8'h00);
    #1 check_eq("post_rst_gnt", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick();
    tick();
    check_eq("post_rst_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("post_rst_rsp_data", 32'(rsp_data), 32'h18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
